// File: rtl/io_controller.sv
// io_controller: memory-mapped UART byte port plus cycle/retired-instruction counters for the MEM stage.
// Build option IO_TX_FIFO_EN: TX buffer is a TX_DEPTH-entry FIFO; otherwise a single holding register.
module io_controller #(
   parameter int TX_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  wea,
   input  logic        re,
   input  logic        inst_retire,
   output logic [31:0] rdata,
   output logic [7:0]  uart_tx_data,
   output logic        uart_tx_valid,
   input  logic        uart_tx_ready,
   input  logic [7:0]  uart_rx_data,
   input  logic        uart_rx_valid,
   output logic        uart_rx_ready
);
   localparam logic [31:0] A_STAT = 32'h8000_0000;
   localparam logic [31:0] A_RXD  = 32'h8000_0004;
   localparam logic [31:0] A_TXD  = 32'h8000_0008;
   localparam logic [31:0] A_CYC  = 32'h8000_0010;
   localparam logic [31:0] A_INS  = 32'h8000_0014;
   localparam logic [31:0] A_CLR  = 32'h8000_0018;

   if (TX_DEPTH < 2 || (TX_DEPTH & (TX_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("TX_DEPTH must be a power of two >= 2");
   end

   logic        w_st, w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
   logic        w_rx_cap, w_rx_rd, w_clr, w_unused;
   logic [7:0]  w_tx_head;
   logic [31:0] w_rd_mux;
   logic        r_rx_full;
   logic [7:0]  r_rx_byte;
   logic [31:0] r_cyc_cnt, r_ins_cnt, r_rdata;

   assign w_st      = |wea;
   assign w_tx_push = w_st && (addr == A_TXD) && !w_tx_full;
   assign w_tx_pop  = !w_tx_empty && uart_tx_ready;
   assign w_clr     = w_st && (addr == A_CLR);
   assign w_unused  = ^wdata[31:8];

`ifdef IO_TX_FIFO_EN
   localparam int PW = $clog2(TX_DEPTH);
   localparam logic [PW:0] DEPTH_C = (PW+1)'(TX_DEPTH);

   logic [7:0]    r_mem [TX_DEPTH];
   logic [PW-1:0] r_wptr, r_rptr;
   logic [PW:0]   r_cnt;

   assign w_tx_full  = (r_cnt == DEPTH_C);
   assign w_tx_empty = (r_cnt == '0);
   assign w_tx_head  = r_mem[r_rptr];

   // Storage has no reset: contents are only observed while r_cnt says they are valid.
   always_ff @(posedge clk) begin
      if (w_tx_push) r_mem[r_wptr] <= wdata[7:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_tx_push) r_wptr <= r_wptr + 1'b1;
         if (w_tx_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_tx_push, w_tx_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end
`else
   logic       r_tx_vld;
   logic [7:0] r_tx_byte;

   assign w_tx_full  = r_tx_vld;
   assign w_tx_empty = !r_tx_vld;
   assign w_tx_head  = r_tx_byte;

   // A push needs an empty register, so push and pop never coincide here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tx_vld  <= 1'b0;
         r_tx_byte <= '0;
      end else begin
         if (w_tx_push) r_tx_byte <= wdata[7:0];
         r_tx_vld <= w_tx_push | (r_tx_vld & !w_tx_pop);
      end
   end
`endif

   assign uart_tx_valid = !w_tx_empty;
   assign uart_tx_data  = w_tx_head;

   assign uart_rx_ready = !r_rx_full;
   assign w_rx_cap      = uart_rx_valid && !r_rx_full;
   assign w_rx_rd       = re && (addr == A_RXD);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_full <= 1'b0;
         r_rx_byte <= '0;
      end else if (w_rx_cap) begin
         r_rx_full <= 1'b1;
         r_rx_byte <= uart_rx_data;
      end else if (w_rx_rd) begin
         r_rx_full <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cyc_cnt <= '0;
         r_ins_cnt <= '0;
      end else if (w_clr) begin
         r_cyc_cnt <= '0;
         r_ins_cnt <= '0;
      end else begin
         r_cyc_cnt <= r_cyc_cnt + 32'd1;
         r_ins_cnt <= r_ins_cnt + {31'd0, inst_retire};
      end
   end

   always_comb begin
      w_rd_mux = '0;
      case (addr)
         A_STAT:  w_rd_mux = {30'd0, r_rx_full, !w_tx_full};
         A_RXD:   w_rd_mux = {24'd0, r_rx_byte};
         A_CYC:   w_rd_mux = r_cyc_cnt;
         A_INS:   w_rd_mux = r_ins_cnt;
         default: w_rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  r_rdata <= '0;
      else if (re) r_rdata <= w_rd_mux;
   end

   assign rdata = r_rdata;
endmodule

// File: tb/tb_io_controller.sv
// Bench for io_controller: random and directed MEM-stage traffic against a queue/counter reference model,
// with a scoreboard monitor comparing load data, TX bytes and handshake flags.
module tb_io_controller;
   localparam logic [31:0] STAT = 32'h8000_0000;
   localparam logic [31:0] RXD  = 32'h8000_0004;
   localparam logic [31:0] TXA  = 32'h8000_0008;
   localparam logic [31:0] CYC  = 32'h8000_0010;
   localparam logic [31:0] INS  = 32'h8000_0014;
   localparam logic [31:0] CLR  = 32'h8000_0018;
`ifdef IO_TX_FIFO_EN
   localparam int DEPTH = 4;
`else
   localparam int DEPTH = 1;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [31:0] addr = '0, wdata = '0;
   logic [3:0]  wea = '0;
   logic        re = 1'b0, inst_retire = 1'b0;
   logic [31:0] rdata;
   logic [7:0]  uart_tx_data;
   logic        uart_tx_valid;
   logic        uart_tx_ready = 1'b0;
   logic [7:0]  uart_rx_data = '0;
   logic        uart_rx_valid = 1'b0;
   logic        uart_rx_ready;

   io_controller #(.TX_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .wea(wea), .re(re),
      .inst_retire(inst_retire), .rdata(rdata), .uart_tx_data(uart_tx_data),
      .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready),
      .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid), .uart_rx_ready(uart_rx_ready)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Scoreboard queues: expected load data, expected TX byte stream, expected {tx_valid, rx_ready} per cycle.
   logic [31:0] rd_q[$];
   logic [7:0]  tx_q[$];
   logic [1:0]  st_q[$];

   // Reference model state as it will be after the coming rising edge.
   logic [31:0] m_cyc, m_ins;
   int          m_txn;
   logic        m_rx_full;
   logic [7:0]  m_rxb;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      m_cyc = '0; m_ins = '0; m_txn = 0; m_rx_full = 1'b0; m_rxb = '0;
   endtask

   // Applies the rules to the inputs currently driven; pushes what the DUT must show.
   task automatic model_step();
      logic [31:0] rv;
      logic        push, pop, nfull;
      st_q.push_back({m_txn != 0, !m_rx_full});
      if (re) begin
         case (addr)
            STAT:    rv = {30'd0, m_rx_full, 1'(m_txn < DEPTH)};
            RXD:     rv = {24'd0, m_rxb};
            CYC:     rv = m_cyc;
            INS:     rv = m_ins;
            default: rv = '0;
         endcase
         rd_q.push_back(rv);
      end
      push = (wea != 0) && (addr == TXA) && (m_txn < DEPTH);
      pop  = (m_txn != 0) && uart_tx_ready;
      if (push) tx_q.push_back(wdata[7:0]);
      m_txn = m_txn + int'(push) - int'(pop);
      nfull = m_rx_full;
      if (re && addr == RXD) nfull = 1'b0;
      if (uart_rx_valid && !m_rx_full) begin
         nfull = 1'b1;
         m_rxb = uart_rx_data;
      end
      m_rx_full = nfull;
      if (wea != 0 && addr == CLR) begin
         m_cyc = '0; m_ins = '0;
      end else begin
         m_cyc = m_cyc + 32'd1;
         m_ins = m_ins + {31'd0, inst_retire};
      end
   endtask

   task automatic step(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we, input logic r,
                       input logic ret, input logic txr, input logic rxv, input logic [7:0] rxd);
      @(negedge clk);
      addr = a; wdata = d; wea = we; re = r; inst_retire = ret;
      uart_tx_ready = txr; uart_rx_valid = rxv; uart_rx_data = rxd;
      model_step();
   endtask

   task automatic idle(input int n, input logic txr);
      for (int k = 0; k < n; k++) step('0, '0, 4'h0, 1'b0, 1'b0, txr, 1'b0, 8'h00);
   endtask

   task automatic do_reset();
      @(negedge clk);
      addr = '0; wdata = '0; wea = '0; re = 1'b0; inst_retire = 1'b0;
      uart_rx_valid = 1'b0;
      rst_n = 1'b0;
      rd_q.delete(); tx_q.delete(); st_q.delete();
      model_reset();
      #1;
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_tx_valid", uart_tx_valid, 1'b0);
      chk("rst_rx_ready", uart_rx_ready, 1'b1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_step();
   endtask

   // Monitor: samples 2 time units after each falling edge, well away from the rising edge.
   initial begin
      logic       rd_pend;
      logic [1:0] e;
      rd_pend = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            rd_pend = 1'b0;
         end else begin
            if (rd_pend) begin
               if (rd_q.size() == 0) chk("rd_underflow", 32'd1, 32'd0);
               else chk("rdata", rdata, rd_q.pop_front());
            end
            rd_pend = re;
            if (st_q.size() != 0) begin
               e = st_q.pop_front();
               chk("tx_valid", uart_tx_valid, e[1]);
               chk("rx_ready", uart_rx_ready, e[0]);
            end
            if (uart_tx_valid && uart_tx_ready) begin
               if (tx_q.size() == 0) chk("tx_unexpected", uart_tx_data, 32'hFFFF_FFFF);
               else chk("tx_byte", uart_tx_data, tx_q.pop_front());
            end
         end
      end
   end

   initial begin
      logic [31:0] a;
      logic [3:0]  we;
      int          sel;
      model_reset();
      do_reset();

      // Idle counting, then cycle counter and status reads.
      idle(10, 1'b0);
      step(CYC, '0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      step(STAT, '0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

      // TX stores while the transmitter stalls: overflow byte is dropped.
      for (int k = 0; k < 5; k++) step(TXA, 32'h41 + k, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      step(STAT, '0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      idle(6, 1'b1);

      // RX byte capture, status, read-out and ready recovery.
      step('0, '0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5A);
      step(STAT, '0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
      step(RXD, '0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
      idle(2, 1'b1);

      // Retire instructions, then clear concurrent with a retire.
      for (int k = 0; k < 7; k++) step('0, '0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
      step(CLR, '0, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
      step(CYC, '0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
      step(INS, '0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
      idle(1, 1'b1);

      // Reset mid-operation with TX bytes queued and an RX byte held.
      for (int k = 0; k < 3; k++) step(TXA, 32'h61 + k, 4'h1, 1'b0, 1'b0, 1'b0, k == 0, 8'h33);
      idle(1, 1'b0);
      do_reset();
      idle(2, 1'b1);

      // Cycle counter wrap, then unmapped read.
      idle(1, 1'b1);
      force dut.r_cyc_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.r_cyc_cnt;
      m_cyc = 32'hFFFF_FFFF + 32'd1;
      step(CYC, '0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
      step(32'h8000_0020, '0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         sel = $urandom_range(0, 9);
         case (sel)
            0:       a = STAT;
            1:       a = RXD;
            2, 3:    a = TXA;
            4:       a = CYC;
            5:       a = INS;
            6:       a = ($urandom_range(0, 9) == 0) ? CLR : STAT;
            7:       a = 32'h8000_0020;
            8:       a = 32'h8000_000C;
            default: a = $urandom;
         endcase
         we = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
         step(a, $urandom, we, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), 8'($urandom));
      end

      idle(8, 1'b1);
      #3;
      chk("tx_drained", tx_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
